// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between requester 0 (CPU) and
// requester 1 (loader/debug). It uses round-robin between the two ports and
// lets port 1 hold the RAM for a bounded locked burst.
//
// Handshake: a requester raises reqX and holds weX/addrX/wdataX stable until
// it sees ackX. ackX is a one-cycle strobe in the cycle the RAM access takes
// place. If reqX is still high in the cycle after ackX, that is a new access.
module mem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] ram_address,
  output logic          ram_write,
  output logic [DW-1:0] ram_datain,
  input  logic [DW-1:0] ram_dataout,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] MAX_BURST_C = BW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;       // 1 = port 1 was served most recently
  logic [BW-1:0] burst_cnt, burst_nxt;
  logic          lock_ok;
  logic [DW-1:0] rdata0_q, rdata1_q;

  assign dbg_state = state;

  // Pick the owner of the next RAM cycle: the lock override wins, then round-robin.
  always_comb begin
    state_nxt = IDLE;
    last_nxt  = last;
    burst_nxt = '0;
    lock_ok   = (state == GRANT1) && lock1 && req1 && (burst_cnt < MAX_BURST_C);
    if (lock_ok)
      state_nxt = GRANT1;
    else if (req0 && req1)
      state_nxt = last ? GRANT0 : GRANT1;
    else if (req0)
      state_nxt = GRANT0;
    else if (req1)
      state_nxt = GRANT1;
    case (state_nxt)
      GRANT0: last_nxt = 1'b0;
      GRANT1: begin
        last_nxt = 1'b1;
        // A fresh entry starts a burst at 1; only locked re-grants extend it.
        if (state != GRANT1)
          burst_nxt = BW'(1);
        else if (lock_ok)
          burst_nxt = burst_cnt + 1'b1;
        else
          burst_nxt = burst_cnt;
      end
      default: ;
    endcase
  end

  // Drive the RAM and the acks from the current owner only.
  always_comb begin
    ram_address = '0;
    ram_datain  = '0;
    ram_write   = 1'b0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    busy        = 1'b0;
    rdata0      = rdata0_q;
    rdata1      = rdata1_q;
    case (state)
      GRANT0: begin
        ram_address = addr0;
        ram_datain  = wdata0;
        ram_write   = we0;
        ack0        = 1'b1;
        busy        = 1'b1;
        if (!we0) rdata0 = ram_dataout;
      end
      GRANT1: begin
        ram_address = addr1;
        ram_datain  = wdata1;
        ram_write   = we1;
        ack1        = 1'b1;
        busy        = 1'b1;
        if (!we1) rdata1 = ram_dataout;
      end
      default: ;
    endcase
  end

  // Arbitration state; last=1 at reset so port 0 wins the first tie.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      last      <= 1'b1;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Capture read data at the end of each port's read cycle and hold it.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (state == GRANT0 && !we0) rdata0_q <= ram_dataout;
      if (state == GRANT1 && !we1) rdata1_q <= ram_dataout;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a RAM model, requester driver tasks and a reference
// model of ownership (who holds the RAM this cycle, how long port 1 has held it).
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          req0, req1, we0, we1, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, ram_write, busy;
  logic [DW-1:0] rdata0, rdata1, ram_datain, ram_dataout;
  logic [AW-1:0] ram_address;
  logic [1:0]    dbg_state;

  mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .clr(clr),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock1(lock1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_address(ram_address), .ram_write(ram_write),
    .ram_datain(ram_datain), .ram_dataout(ram_dataout),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / RAM model
  always #5 clk = ~clk;

  logic [DW-1:0] ram [64];
  logic          init_we;
  logic [5:0]    init_a;
  logic [DW-1:0] init_d;

  always @(posedge clk) begin
    if (init_we) ram[init_a] <= init_d;
    else if (ram_write) ram[ram_address[5:0]] <= ram_datain;
  end
  assign ram_dataout = ram[ram_address[5:0]];

  // reference model and scoreboard
  logic [DW-1:0] ref_mem [64];
  int            m_grant;   // 0 = nobody, 1 = port 0, 2 = port 1
  int            m_last;    // port served most recently
  int            m_run;     // length of port 1's current tenure
  logic [DW-1:0] m_rd0, m_rd1;
  bit            done0, done1;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_grant = 0;
    m_last  = 1;
    m_run   = 0;
    m_rd0   = '0;
    m_rd1   = '0;
    done0   = 0;
    done1   = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model to the next cycle.
  task automatic cycle();
    logic [31:0] e_addr, e_din, e_rd0, e_rd1;
    logic        e_we;
    bit          lock;
    int          nxt;
    @(negedge clk);
    e_addr = '0; e_din = '0; e_we = 1'b0; e_rd0 = m_rd0; e_rd1 = m_rd1;
    if (m_grant == 1) begin
      e_addr = addr0; e_din = wdata0; e_we = we0;
      if (!we0) e_rd0 = ref_mem[addr0[5:0]];
    end else if (m_grant == 2) begin
      e_addr = addr1; e_din = wdata1; e_we = we1;
      if (!we1) e_rd1 = ref_mem[addr1[5:0]];
    end
    check("ack0", ack0, m_grant == 1);
    check("ack1", ack1, m_grant == 2);
    check("busy", busy, m_grant != 0);
    check("ram_write", ram_write, e_we);
    check("ram_address", ram_address, e_addr);
    check("ram_datain", ram_datain, e_din);
    check("rdata0", rdata0, e_rd0);
    check("rdata1", rdata1, e_rd1);
    // effect of this cycle's access
    if (m_grant != 0) begin
      if (e_we) ref_mem[e_addr[5:0]] = e_din;
      else if (m_grant == 1) m_rd0 = e_rd0;
      else m_rd1 = e_rd1;
    end
    done0 = (m_grant == 1);
    done1 = (m_grant == 2);
    // who owns the next cycle
    lock = (m_grant == 2) && lock1 && req1 && (m_run < MB);
    if (lock)              nxt = 2;
    else if (req0 && req1) nxt = (m_last == 1) ? 1 : 2;
    else if (req0)         nxt = 1;
    else if (req1)         nxt = 2;
    else                   nxt = 0;
    if (nxt == 2) m_run = (m_grant != 2) ? 1 : (lock ? m_run + 1 : m_run);
    else          m_run = 0;
    if (nxt != 0) m_last = nxt - 1;
    m_grant = nxt;
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic set_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  task automatic new_access(input int p, input int pct);
    if ($urandom_range(0, 99) < pct)
      set_req(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom);
    else if (p == 0) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  // A port may change its request only when idle or just acknowledged.
  task automatic serve(input int pct0, input int pct1);
    if (!req0 || done0) new_access(0, pct0);
    if (!req1 || done1) new_access(1, pct1);
  endtask

  int run, max_run;

  initial begin
    clr = 1'b1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    init_we = 1'b1; init_a = '0; init_d = '0;
    model_reset();
    for (int i = 0; i < 64; i++) begin
      init_a = 6'(i);
      init_d = (i == 4) ? 32'h0050_0093 : (i == 16) ? 32'h1111_1111 : $urandom;
      ref_mem[i] = init_d;
      @(posedge clk);
      #1;
    end
    init_we = 1'b0;
    // reset values
    @(negedge clk);
    check("rst_ack0", ack0, 0);
    check("rst_ack1", ack1, 0);
    check("rst_busy", busy, 0);
    check("rst_ram_write", ram_write, 0);
    check("rst_ram_address", ram_address, 0);
    check("rst_rdata0", rdata0, 0);
    check("rst_rdata1", rdata1, 0);
    @(posedge clk);
    #1;
    clr = 1'b0;

    // single read from port 0, held after req drops
    set_req(0, 1'b0, 32'h4, '0);
    repeat (4) begin cycle(); serve(0, 0); end
    check("rd0_hold", rdata0, 32'h0050_0093);

    // port 1 writes, port 0 reads the same word
    set_req(1, 1'b1, 32'h20, 32'hCAFE_F00D);
    set_req(0, 1'b0, 32'h20, '0);
    repeat (4) begin cycle(); serve(0, 0); end
    check("wr_then_rd", rdata0, 32'hCAFE_F00D);

    // sustained contention without lock
    serve(100, 100);
    repeat (12) begin cycle(); serve(100, 100); end

    // lock burst: longest run of port-1 grants must be exactly MB
    lock1 = 1'b1;
    run = 0; max_run = 0;
    repeat (16) begin
      cycle();
      run = done1 ? run + 1 : 0;
      if (run > max_run) max_run = run;
      serve(100, 100);
    end
    check("lock_run", max_run, MB);
    lock1 = 1'b0;
    repeat (4) begin cycle(); serve(0, 0); end

    // single port-1 access, then return to idle
    set_req(1, 1'b0, 32'h5, '0);
    repeat (4) begin cycle(); serve(0, 0); end

    // randomized traffic
    repeat (3000) begin
      cycle();
      lock1 = ($urandom_range(0, 3) != 0);
      serve(60, 60);
    end
    lock1 = 1'b0;
    repeat (6) begin cycle(); serve(0, 0); end

    // reset in the middle of a port-1 write
    set_req(1, 1'b1, 32'h10, 32'h0000_DEAD);
    cycle();
    #2;
    check("pre_clr_write", ram_write, 1);
    clr = 1'b1;
    #1;
    check("clr_ram_write", ram_write, 0);
    check("clr_ack1", ack1, 0);
    check("clr_busy", busy, 0);
    check("clr_ram_address", ram_address, 0);
    check("clr_rdata0", rdata0, 0);
    check("clr_rdata1", rdata1, 0);
    req1 = 1'b0;
    @(posedge clk);
    #1;
    check("clr_no_commit", ram[16], ref_mem[16]);
    clr = 1'b0;
    model_reset();
    repeat (3) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port RAM between requester 0 (CPU memory port: fetch and load/store) and requester 1 (program loader / debug port). It sits between the requesters and the RAM, serialises their accesses with a req/ack handshake, applies round-robin fairness and supports bounded lock bursts for requester 1. Stalling the multi-cycle CPU until ack is the control FSM's job; this block only sequences RAM ownership.

## Interface
- AW, default 32: address width.
- DW, default 32: data width.
- MAX_BURST, default 8: maximum consecutive locked grants to requester 1 (≥1).

Ports:
- clk  in  1  single clock; all state on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- req0 / req1  in  1  access request, held until ack.
- we0 / we1  in  1  1 = write, 0 = read; stable while req high.
- addr0 / addr1  in  AW  word address; stable while req high.
- wdata0 / wdata1  in  DW  write data; stable while req high.
- lock1  in  1  requester 1 asks to keep ownership for its next request.
- ack0 / ack1  out  1  one-cycle completion strobe.
- rdata0 / rdata1  out  DW  read data; valid in ack cycle and held until that port's next read ack.
- ram_address  out  AW  to RAM address.
- ram_write  out  1  to RAM write enable.
- ram_datain  out  DW  to RAM write data.
- ram_dataout  in  DW  from RAM, combinational read of ram_address.
- busy  out  1  high in any GRANT state.

## Operation
- States: IDLE, GRANT0, GRANT1. One RAM access per GRANT cycle.
- IDLE: ram_write=0, ram_address=0, ram_datain=0, acks 0.
- GRANTx: ram_address=addrx, ram_datain=wdatax, ram_write=wex, ackx=1 (Moore, from state only). The RAM write commits at the rising edge ending GRANTx. On a read, rdatax = ram_dataout during GRANTx and is registered at the edge for holding.
- Winner selection at every edge leaving IDLE or GRANTx:
  - Only one req high: grant it.
  - Both high: grant the port not served last (last-served pointer `last`, updated on every grant).
  - Lock override: if current state is GRANT1, lock1=1, req1=1 and burst_cnt < MAX_BURST, grant 1 regardless of req0.
  - No req: go to IDLE.
- A requester whose req stays high in the cycle after its ack is issuing a new access; the same port can win back-to-back only if the other port is not requesting or the lock override applies.
- burst_cnt: set to 1 on entering GRANT1 from any state other than GRANT1. Increments on each GRANT1→GRANT1 transition taken because of the lock override. Cleared on leaving GRANT1. Saturates so that at MAX_BURST the lock is ignored for one arbitration.
- Requests sampled in GRANTx are for the next access. The current access's inputs are those of the granted port in that cycle.
- Undefined: a requester changing we/addr/wdata or dropping req before ack. The arbiter takes no corrective action.

## Timing
- Reset values (async, immediate on clr rising): state IDLE, last=1 (port 0 wins first tie), burst_cnt=0, rdata0=rdata1=0. All combinational outputs are therefore 0.
- Latency from IDLE: req asserted in cycle n → GRANT in cycle n+1 → ack in n+1 → read data registered at end of n+1.
- Back-to-back: GRANTx→GRANTy with no IDLE bubble. Sustained throughput is 1 access/cycle.
- Worst-case wait for port 0 with lock1 held: MAX_BURST+1 cycles after request.
- clr mid-GRANT: ram_write drops to 0 immediately, so no write commits. No ack is issued after clr, and the requester must re-issue.
- Simultaneous req0 and req1 rising from IDLE after reset: port 0 wins, then port 1.

## Test plan
- Reset: assert clr mid-GRANT1 write (addr1=0x10, wdata1=0xDEAD) → ram_write=0 at once; state IDLE; RAM[0x10] unchanged; rdata0/1=0.
- Single read: req0, we0=0, addr0=0x4, RAM[0x4]=0x00500093 → ack0 one cycle later; rdata0=0x00500093, held after req0 drops.
- Write then read: port 1 writes 0xCAFEF00D to 0x20, then port 0 reads 0x20 → ack1, then ack0 on the next grant; rdata0=0xCAFEF00D.
- Contention: req0 and req1 held high continuously, lock1=0 → acks alternate 0,1,0,1… with no IDLE cycles; busy stays 1.
- Lock burst: MAX_BURST=4, lock1=1, req1 and req0 high → exactly 4 consecutive ack1, then ack0, then ack1 resumes.
- Idle return: single req1 access, then no requests → GRANT1 for one cycle then IDLE; busy=0; ram_write=0; ram_address=0.
